// File: rtl/count_monitor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : count_monitor_pkg                                             |
// | Brief    : Shared types and constants for the count_monitor block.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package count_monitor_pkg;

  // Widths of the observed counter words and the mismatch total
  localparam int COUNT3_W  = 8;
  localparam int COUNT2_W  = 4;
  localparam int ERR_CNT_W = 8;

  // Default tuning of lock acquisition and fault detection
  localparam int LOCK_CYCLES_DEF = 4;
  localparam int ERR_THRESH_DEF  = 3;

  // Monitor state
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_TRACK = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

endpackage : count_monitor_pkg
`default_nettype wire

// File: rtl/count_step_predict.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : count_step_predict                                            |
// | Brief    : Combinational next-value predictor for a {count2,count3}      |
// |            cascaded up/down counter. count2 only moves when count3 wraps.|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module count_step_predict
  import count_monitor_pkg::*;
(
  input  logic                direction,
  input  logic [COUNT3_W-1:0] prev_count3,
  input  logic [COUNT2_W-1:0] prev_count2,
  output logic [COUNT3_W-1:0] exp_count3,
  output logic [COUNT2_W-1:0] exp_count2
);

  // Predict one step: low word always moves, high word only on low-word wrap
  always_comb begin
    exp_count3 = prev_count3;
    exp_count2 = prev_count2;
    if (direction) begin
      exp_count3 = prev_count3 + 1'b1;
      if (prev_count3 == '1) begin
        exp_count2 = prev_count2 + 1'b1;
      end
    end else begin
      exp_count3 = prev_count3 - 1'b1;
      if (prev_count3 == '0) begin
        exp_count2 = prev_count2 - 1'b1;
      end
    end
  end

endmodule : count_step_predict
`default_nettype wire

// File: rtl/count_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : count_monitor                                                 |
// | Brief    : Watches a cascaded {count2,count3} up/down counter, declares  |
// |            lock after LOCK_CYCLES good steps, counts mismatches and      |
// |            raises fault after ERR_THRESH consecutive mismatches.         |
// | Config   : COUNT_MONITOR_STICKY_EN defined   -> FAULT held until reset.  |
// |            COUNT_MONITOR_STICKY_EN undefined -> FAULT recovers to TRACK  |
// |            after LOCK_CYCLES consecutive good steps.                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter int ERR_THRESH  = ERR_THRESH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         direction,
  input  logic [COUNT3_W-1:0]          count3,
  input  logic [COUNT2_W-1:0]          count2,
  output logic                         locked,
  output logic                         err_pulse,
  output logic [ERR_CNT_W-1:0]         err_count,
  output logic                         fault,
  output logic [COUNT2_W+COUNT3_W-1:0] bad_value
);

  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam int ERR_W  = $clog2(ERR_THRESH + 1);

  // Registered sample S and previous sample P
  logic                s_valid_q, s_valid_d;
  logic                s_dir_q,   s_dir_d;
  logic [COUNT3_W-1:0] s_c3_q,    s_c3_d;
  logic [COUNT2_W-1:0] s_c2_q,    s_c2_d;
  logic                p_valid_q, p_valid_d;
  logic                p_dir_q,   p_dir_d;
  logic [COUNT3_W-1:0] p_c3_q,    p_c3_d;
  logic [COUNT2_W-1:0] p_c2_q,    p_c2_d;

  // Control state
  state_t                       state_q,     state_d;
  logic [LOCK_W-1:0]            lock_cnt_q,  lock_cnt_d;
  logic [ERR_W-1:0]             err_run_q,   err_run_d;
  logic                         err_pulse_q, err_pulse_d;
  logic [ERR_CNT_W-1:0]         err_count_q, err_count_d;
  logic [COUNT2_W+COUNT3_W-1:0] bad_value_q, bad_value_d;

  // Step evaluation
  logic [COUNT3_W-1:0] exp_c3;
  logic [COUNT2_W-1:0] exp_c2;
  logic                both_valid;
  logic                dir_change;
  logic                step_good;
  logic                step_bad;

  // Expected S derived from P in the direction S was captured with
  count_step_predict u_predict (
    .direction   (s_dir_q),
    .prev_count3 (p_c3_q),
    .prev_count2 (p_c2_q),
    .exp_count3  (exp_c3),
    .exp_count2  (exp_c2)
  );

  // Capture inputs once; the old sample shifts into the reference slot
  always_comb begin
    s_valid_d = 1'b1;
    s_dir_d   = direction;
    s_c3_d    = count3;
    s_c2_d    = count2;
    p_valid_d = s_valid_q;
    p_dir_d   = s_dir_q;
    p_c3_d    = s_c3_q;
    p_c2_d    = s_c2_q;
  end

  // Sample pipeline registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_valid_q <= 1'b0;
      s_dir_q   <= 1'b0;
      s_c3_q    <= '0;
      s_c2_q    <= '0;
      p_valid_q <= 1'b0;
      p_dir_q   <= 1'b0;
      p_c3_q    <= '0;
      p_c2_q    <= '0;
    end else begin
      s_valid_q <= s_valid_d;
      s_dir_q   <= s_dir_d;
      s_c3_q    <= s_c3_d;
      s_c2_q    <= s_c2_d;
      p_valid_q <= p_valid_d;
      p_dir_q   <= p_dir_d;
      p_c3_q    <= p_c3_d;
      p_c2_q    <= p_c2_d;
    end
  end

  // Classify the current S/P pair; a direction flip is never judged
  always_comb begin
    both_valid = s_valid_q && p_valid_q;
    dir_change = both_valid && (s_dir_q != p_dir_q);
    step_good  = both_valid && !dir_change &&
                 (s_c3_q == exp_c3) && (s_c2_q == exp_c2);
    step_bad   = both_valid && !dir_change && !step_good;
  end

  // Next-state, lock/error counters and error reporting
  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    err_run_d   = err_run_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    bad_value_d = bad_value_q;

    // A new direction becomes the new reference: lock progress restarts
    if (dir_change) begin
      lock_cnt_d = '0;
    end

    // Reported mismatches only exist once locked (TRACK or FAULT)
    if (step_bad && (state_q == ST_TRACK || state_q == ST_FAULT)) begin
      err_pulse_d = 1'b1;
      bad_value_d = {s_c2_q, s_c3_q};
      if (err_count_q != '1) begin
        err_count_d = err_count_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (s_valid_q) begin
          state_d    = ST_SYNC;
          lock_cnt_d = '0;
        end
      end

      ST_SYNC: begin
        if (step_bad) begin
          lock_cnt_d = '0;
        end else if (step_good) begin
          if (lock_cnt_q == LOCK_W'(LOCK_CYCLES - 1)) begin
            state_d    = ST_TRACK;
            lock_cnt_d = '0;
            err_run_d  = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
      end

      ST_TRACK: begin
        if (step_bad) begin
          if (err_run_q == ERR_W'(ERR_THRESH - 1)) begin
            state_d    = ST_FAULT;
            err_run_d  = '0;
            lock_cnt_d = '0;
          end else begin
            err_run_d = err_run_q + 1'b1;
          end
        end else if (step_good) begin
          err_run_d = '0;
        end
      end

      ST_FAULT: begin
        if (step_bad) begin
          lock_cnt_d = '0;
        end else if (step_good) begin
`ifdef COUNT_MONITOR_STICKY_EN
          // Terminal: good steps are accepted but never release the fault
          lock_cnt_d = '0;
`else
          if (lock_cnt_q == LOCK_W'(LOCK_CYCLES - 1)) begin
            state_d    = ST_TRACK;
            lock_cnt_d = '0;
            err_run_d  = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      lock_cnt_q  <= '0;
      err_run_q   <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      bad_value_q <= '0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      err_run_q   <= err_run_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      bad_value_q <= bad_value_d;
    end
  end

  // Status outputs follow the registered state directly
  always_comb begin
    locked    = (state_q == ST_TRACK);
    fault     = (state_q == ST_FAULT);
    err_pulse = err_pulse_q;
    err_count = err_count_q;
    bad_value = bad_value_q;
  end

endmodule : count_monitor
`default_nettype wire

// File: tb/tb_count_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_count_monitor                                              |
// | Brief    : Directed self-checking bench for count_monitor.               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_count_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        direction = 1'b1;
  logic [7:0]  count3 = 8'd0;
  logic [3:0]  count2 = 4'd0;
  logic        locked;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic        fault;
  logic [11:0] bad_value;

  int checks = 0;
  int failures = 0;

  count_monitor dut (
    .clk       (clk),
    .reset     (reset),
    .direction (direction),
    .count3    (count3),
    .count2    (count2),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .fault     (fault),
    .bad_value (bad_value)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one {count2,count3} value and let the next edge capture it
  task automatic drive(input logic [11:0] v);
    count2 = v[11:8];
    count3 = v[7:0];
    tick();
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [11:0] v, input logic dir);
    reset = 1'b0;
    direction = dir;
    count2 = v[11:8];
    count3 = v[7:0];
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_locked",    12'(locked),    12'd0);
    chk("rst_err_pulse", 12'(err_pulse), 12'd0);
    chk("rst_err_count", 12'(err_count), 12'd0);
    chk("rst_fault",     12'(fault),     12'd0);
    chk("rst_bad_value", bad_value,      12'd0);
    reset = 1'b1;

    // Clean up-count from {0,0}
    for (int i = 0; i < 20; i++) begin
      drive(12'(i));
      if (i == 4) chk("lock_not_yet", 12'(locked), 12'd0);
      if (i == 6) chk("lock_cycle7",  12'(locked), 12'd1);
    end
    chk("clean_err_count", 12'(err_count), 12'd0);
    chk("clean_err_pulse", 12'(err_pulse), 12'd0);
    chk("clean_fault",     12'(fault),     12'd0);

    // Combined wrap upward {15,250}..{0,3}
    do_reset(12'hFFA, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(12'hFFA + 12'(i));
      if (i >= 1) chk("wrap_up_pulse", 12'(err_pulse), 12'd0);
    end
    chk("wrap_up_locked", 12'(locked),    12'd1);
    chk("wrap_up_count",  12'(err_count), 12'd0);

    // Direction flip mid-TRACK, then downward through {0,0}->{15,255}
    direction = 1'b0;
    drive(12'h002);
    chk("dirflip_pulse",  12'(err_pulse), 12'd0);
    drive(12'h001);
    chk("dirflip_pulse2", 12'(err_pulse), 12'd0);
    drive(12'h000);
    chk("wrap_dn_pulse",  12'(err_pulse), 12'd0);
    drive(12'hFFF);
    chk("wrap_dn_pulse",  12'(err_pulse), 12'd0);
    drive(12'hFFE);
    chk("wrap_dn_pulse",  12'(err_pulse), 12'd0);
    drive(12'hFFD);
    chk("wrap_dn_pulse",  12'(err_pulse), 12'd0);
    drive(12'hFFC);
    chk("wrap_dn_pulse",  12'(err_pulse), 12'd0);
    chk("wrap_dn_locked", 12'(locked),    12'd1);
    chk("wrap_dn_count",  12'(err_count), 12'd0);

    // Single injected error 0x37 where 0x36 expected
    do_reset(12'h030, 1'b1);
    for (int i = 0; i < 6; i++) drive(12'h030 + 12'(i));
    chk("inj_locked0", 12'(locked), 12'd1);
    drive(12'h037);
    chk("inj_latency_pulse0", 12'(err_pulse), 12'd0);
    drive(12'h037);
    chk("inj_pulse",     12'(err_pulse), 12'd1);
    chk("inj_err_count", 12'(err_count), 12'd1);
    chk("inj_bad_value", bad_value,      12'h037);
    chk("inj_locked",    12'(locked),    12'd1);
    drive(12'h038);
    chk("inj2_pulse",  12'(err_pulse), 12'd1);
    chk("inj2_count",  12'(err_count), 12'd2);
    chk("inj2_locked", 12'(locked),    12'd1);
    drive(12'h039);
    chk("inj_recover_pulse", 12'(err_pulse), 12'd0);
    chk("inj_recover_lock",  12'(locked),    12'd1);

    // Stalled counter: three mismatches force FAULT
    drive(12'h039);
    chk("stall_pre_pulse", 12'(err_pulse), 12'd0);
    drive(12'h039);
    chk("stall1_pulse", 12'(err_pulse), 12'd1);
    chk("stall1_count", 12'(err_count), 12'd3);
    drive(12'h039);
    chk("stall2_pulse", 12'(err_pulse), 12'd1);
    chk("stall2_fault", 12'(fault),     12'd0);
    drive(12'h03A);
    chk("stall3_pulse",  12'(err_pulse), 12'd1);
    chk("stall3_count",  12'(err_count), 12'd5);
    chk("stall3_fault",  12'(fault),     12'd1);
    chk("stall3_locked", 12'(locked),    12'd0);
    chk("stall3_bad",    bad_value,      12'h039);
    drive(12'h03B);
    chk("fault_good_pulse", 12'(err_pulse), 12'd0);
    drive(12'h03C);
    drive(12'h03D);
    chk("fault_hold3", 12'(fault), 12'd1);
    drive(12'h03E);
`ifdef COUNT_MONITOR_STICKY_EN
    chk("sticky_fault",  12'(fault),  12'd1);
    chk("sticky_locked", 12'(locked), 12'd0);
`else
    chk("recover_fault",  12'(fault),  12'd0);
    chk("recover_locked", 12'(locked), 12'd1);
`endif
    chk("recover_count", 12'(err_count), 12'd5);

    // Saturation under 300 stalled samples
    for (int i = 0; i < 300; i++) drive(12'h03E);
    chk("sat_count", 12'(err_count), 12'd255);
    chk("sat_pulse", 12'(err_pulse), 12'd1);
    chk("sat_fault", 12'(fault),     12'd1);
    chk("sat_bad",   bad_value,      12'h03E);

    // Asynchronous reset mid-FAULT
    #3;
    reset = 1'b0;
    #1;
    chk("arst_locked",    12'(locked),    12'd0);
    chk("arst_err_pulse", 12'(err_pulse), 12'd0);
    chk("arst_err_count", 12'(err_count), 12'd0);
    chk("arst_fault",     12'(fault),     12'd0);
    chk("arst_bad_value", bad_value,      12'd0);

    // SYNC mismatch clears lock progress silently
    do_reset(12'h000, 1'b1);
    drive(12'h000);
    drive(12'h001);
    drive(12'h002);
    drive(12'h009);
    drive(12'h00A);
    chk("sync_bad_pulse", 12'(err_pulse), 12'd0);
    chk("sync_bad_count", 12'(err_count), 12'd0);
    drive(12'h00B);
    drive(12'h00C);
    drive(12'h00D);
    chk("sync_relock_not_yet", 12'(locked), 12'd0);
    drive(12'h00E);
    chk("sync_relock", 12'(locked), 12'd1);
    drive(12'h00F);
    chk("sync_final_pulse", 12'(err_pulse), 12'd0);
    chk("sync_final_count", 12'(err_count), 12'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_count_monitor
`default_nettype wire

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter LOCK_CYCLES, default 4: consecutive correct steps required to declare lock.
REQ-002 Parameter ERR_THRESH, default 3: consecutive mismatches in TRACK that force FAULT.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 direction  input  1  1 = counter counting up, 0 = counting down.
REQ-006 count3  input  8  low counter word under observation.
REQ-007 count2  input  4  high counter word under observation.
REQ-008 locked  output  1  high while state is TRACK.
REQ-009 err_pulse  output  1  one-cycle strobe per detected mismatch.
REQ-010 err_count  output  8  saturating total mismatch count.
REQ-011 fault  output  1  high while state is FAULT; drives error LED.
REQ-012 bad_value  output  12  {count2,count3} of the most recent mismatching sample.

Function
REQ-013 Inputs shall be registered once; all checks use the registered sample (S) and the previous registered sample (P).
REQ-014 Expected step: up -> count3 = P.count3+1 mod 256; down -> P.count3-1 mod 256.
REQ-015 count2 shall change by +1 (up) only when count3 wraps 255->0, by -1 (down) only when 0->255, mod 16; otherwise hold.
REQ-016 Combined wrap: up from {15,255} expects {0,0}; down from {0,0} expects {15,255}.
REQ-017 A change of direction between P and S: that sample is not checked; it is taken as the new reference (no error, lock counter cleared).
REQ-018 States: IDLE, SYNC, TRACK, FAULT.
REQ-019 IDLE -> SYNC on the first cycle after reset deassertion once a registered sample exists.
REQ-020 SYNC: each correct step increments lock counter; any mismatch clears it without err_pulse; reaching LOCK_CYCLES -> TRACK.
REQ-021 TRACK: mismatch -> err_pulse, err_count+1, bad_value<=S; ERR_THRESH consecutive mismatches -> FAULT; a correct step clears the consecutive counter.
REQ-022 FAULT: checking continues and errors are still counted; exit behaviour per REQ-029/030.
REQ-023 err_pulse latency: asserted exactly 2 clk cycles after the offending value is present at the inputs.
REQ-024 err_count saturates at 255; further mismatches still pulse err_pulse.
REQ-025 Input held constant (counter stalled) counts as a mismatch every cycle in TRACK.

Reset
REQ-026 Asserting reset at any time, including mid-TRACK or FAULT, shall immediately force IDLE.
REQ-027 Reset values: locked=0, err_pulse=0, err_count=0, fault=0, bad_value=0, all internal counters 0, sample registers 0.

Configuration
REQ-028 Macro COUNT_MONITOR_STICKY_EN selects fault recovery policy.
REQ-029 Defined: FAULT is terminal until reset; fault stays 1.
REQ-030 Undefined: in FAULT, LOCK_CYCLES consecutive correct steps -> TRACK, fault=0; err_count retained.

Structure
REQ-031 Package count_monitor_pkg shall hold the state enum, COUNT3_W=8, COUNT2_W=4, and the default LOCK_CYCLES/ERR_THRESH constants.
REQ-032 Sub-module count_step_predict shall compute the expected {count2,count3} from P and direction (purely combinational); FSM and counters stay in count_monitor.

Verification
REQ-033 Clean up-count from {0,0}, direction=1, 20 cycles -> locked=1 at cycle 7 after reset release, err_count=0.
REQ-034 Up-count through {15,254},{15,255},{0,0},{0,1} -> no err_pulse; repeat downward through {0,0}->{15,255} -> no err_pulse.
REQ-035 In TRACK inject single value 0x37 where 0x36 expected -> one err_pulse 2 cycles later, err_count=1, bad_value=0x037 (then recovery: second mismatch also counted as the sequence resumes), locked stays 1.
REQ-036 Hold inputs constant 3 cycles in TRACK -> 3 err_pulses, fault=1; with STICKY_EN fault held until reset; without, 4 correct steps return locked=1, fault=0.
REQ-037 Toggle direction mid-TRACK -> no err_pulse, lock counter restarts; reset asserted mid-FAULT -> all outputs 0 on same edge.
REQ-038 Force 300 mismatches -> err_count=255, err_pulse still strobes.
